// File: rtl/asi_pkg.sv
// asi_pkg: shared types and defaults for the AXI slave interface (ASI) user-side blocks.
// Holds the memory arbiter state type and the width/latency defaults used by the top.
package asi_pkg;

  // Default AXI address/data widths and memory read latency (wait states).
  localparam int AXI_AW         = 32;
  localparam int AXI_DW         = 32;
  localparam int SLV_WS         = 1;

  // Deepest read-valid delay line the arbiter supports.
  localparam int ARB_MAX_RD_LAT = 8;

  // Memory port owner: nobody yet, the read path or the write path.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GR_R = 2'd1,
    ARB_GR_W = 2'd2
  } arb_st_e;

endpackage

// File: rtl/asi_vld_dly.sv
// asi_vld_dly: 1-bit valid delay line of DEPTH stages with asynchronous active-low reset.
// DEPTH = 0 gives a straight combinational pass-through.
module asi_vld_dly #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  output logic out_vld
);

  if (DEPTH == 0) begin : g_pass
    assign out_vld = in_vld;
  end else begin : g_pipe
    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    // Shift the new valid in at stage 0; the oldest stage drives the output.
    always_comb begin
      pipe_d[0] = in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    // Delay-line register; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= pipe_d;
    end

    assign out_vld = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/asi_mem_arbiter.sv
// asi_mem_arbiter: shares the single user-side memory port between the AXI slave read and
// write paths. Level grants are held for a whole burst, the winner's beat is muxed onto
// mem_*, and read-data valid is regenerated through an RD_LAT-deep delay line.
// Build option: define ASI_ARB_RPRIO_EN for fixed read priority; otherwise the port is
// handed over at burst boundaries and parks with the last owner.
// Handshake: a slave may assert *_busy only while it holds its grant; a grant changes
// owner only at a burst boundary (owner not busy, or busy on its last beat) and the new
// grant becomes visible on the following cycle.
import asi_pkg::*;

module asi_mem_arbiter #(
  parameter int AW     = AXI_AW,
  parameter int DW     = AXI_DW,
  parameter int RD_LAT = SLV_WS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r_req,
  input  logic          r_busy,
  input  logic          r_last,
  input  logic [AW-1:0] r_addr,
  output logic          rgranted,
  input  logic          w_req,
  input  logic          w_busy,
  input  logic          w_last,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  input  logic [DW/8-1:0] w_strb,
  output logic          wgranted,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rslverr,
  output logic [DW-1:0] m_rdata,
  output logic          m_rvalid,
  output logic          m_rslverr,
  output logic          arb_err
);

  arb_st_e state_q, state_d;
  logic    rgranted_q, rgranted_d;
  logic    wgranted_q, wgranted_d;
  logic    arb_err_q, arb_err_d;
  logic    r_release, w_release;
  logic    rd_issue;

  // A burst ends on the owner's last beat.
  assign r_release = r_busy & r_last;
  assign w_release = w_busy & w_last;

  // Owner selection: change hands only at a burst boundary, never mid-burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef ASI_ARB_RPRIO_EN
      ARB_IDLE: begin
        if (r_req)      state_d = ARB_GR_R;
        else if (w_req) state_d = ARB_GR_W;
      end
      ARB_GR_R: begin
        if (w_req & ~r_req & ~r_busy) state_d = ARB_GR_W;
      end
      ARB_GR_W: begin
        if (r_req & (w_release | ~w_busy)) state_d = ARB_GR_R;
      end
`else
      ARB_IDLE: begin
        if (w_req)      state_d = ARB_GR_W;
        else if (r_req) state_d = ARB_GR_R;
      end
      ARB_GR_R: begin
        if (w_req & (r_release | ~r_busy)) state_d = ARB_GR_W;
      end
      ARB_GR_W: begin
        if (r_req & (w_release | ~w_busy)) state_d = ARB_GR_R;
      end
`endif
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grants are registered decodes of the next owner, so they line up with state_q.
  always_comb begin
    rgranted_d = (state_d == ARB_GR_R);
    wgranted_d = (state_d == ARB_GR_W);
  end

  // A beat without grant (which covers both paths busy at once) latches the error.
  always_comb begin
    arb_err_d = arb_err_q | (r_busy & ~rgranted_q) | (w_busy & ~wgranted_q);
  end

  // Arbiter state, grants and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rgranted_q <= 1'b0;
      wgranted_q <= 1'b0;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rgranted_q <= rgranted_d;
      wgranted_q <= wgranted_d;
      arb_err_q  <= arb_err_d;
    end
  end

  assign rgranted = rgranted_q;
  assign wgranted = wgranted_q;
  assign arb_err  = arb_err_q;

  // Memory port mux: only the granted path's beat reaches the memory.
  assign mem_en    = (rgranted_q & r_busy) | (wgranted_q & w_busy);
  assign mem_we    = wgranted_q & w_busy;
  assign mem_addr  = wgranted_q ? w_addr : r_addr;
  assign mem_wdata = w_data;
  assign mem_be    = mem_we ? w_strb : '1;

  // Read data returns RD_LAT cycles after the read strobe; the line keeps shifting across
  // owner changes so earlier reads still return in order.
  assign rd_issue = mem_en & ~mem_we;

  asi_vld_dly #(
    .DEPTH (RD_LAT)
  ) u_rd_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_issue),
    .out_vld (m_rvalid)
  );

  assign m_rdata   = mem_rdata;
  assign m_rslverr = mem_rslverr;

endmodule
